// File: rtl/video_pattern_gen_pkg.sv
// Shared encodings for the video test-pattern generator: pattern modes, the 3-bit
// RGB colour masks used for the bar table, and the fixed output latency.
package patgen_pkg;

    typedef enum logic [2:0] {
        PAT_BAR    = 3'b000,
        PAT_GRID   = 3'b001,
        PAT_HRAMP  = 3'b010,
        PAT_SINGLE = 3'b011,
        PAT_VRAMP  = 3'b100,
        PAT_CHECK  = 3'b101
    } pat_mode_e;

    // Colours are {r,g,b} on/off masks; the top expands each bit to a full channel.
    localparam logic [2:0] COL_BLACK   = 3'b000;
    localparam logic [2:0] COL_BLUE    = 3'b001;
    localparam logic [2:0] COL_GREEN   = 3'b010;
    localparam logic [2:0] COL_CYAN    = 3'b011;
    localparam logic [2:0] COL_RED     = 3'b100;
    localparam logic [2:0] COL_MAGENTA = 3'b101;
    localparam logic [2:0] COL_YELLOW  = 3'b110;
    localparam logic [2:0] COL_WHITE   = 3'b111;

    localparam int PAT_LAT = 3;

    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Configuration inputs and video outputs of the pattern generator.
// master = generator side, slave = the block that programs and consumes it.
interface video_pattern_gen_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 12
);
    logic [2:0]        I_mode;
    logic [DATA_W-1:0] I_single_r, I_single_g, I_single_b;
    logic [CNT_W-1:0]  I_h_total, I_h_sync, I_h_bporch, I_h_res;
    logic [CNT_W-1:0]  I_v_total, I_v_sync, I_v_bporch, I_v_res;
    logic              I_hs_pol, I_vs_pol;
    logic              O_de, O_hs, O_vs, O_sof;
    logic [DATA_W-1:0] O_data_r, O_data_g, O_data_b;
    logic [15:0]       O_frame_cnt;

    modport master (
        input  I_mode, I_single_r, I_single_g, I_single_b,
               I_h_total, I_h_sync, I_h_bporch, I_h_res,
               I_v_total, I_v_sync, I_v_bporch, I_v_res,
               I_hs_pol, I_vs_pol,
        output O_de, O_hs, O_vs, O_sof, O_data_r, O_data_g, O_data_b, O_frame_cnt
    );

    modport slave (
        output I_mode, I_single_r, I_single_g, I_single_b,
               I_h_total, I_h_sync, I_h_bporch, I_h_res,
               I_v_total, I_v_sync, I_v_bporch, I_v_res,
               I_hs_pol, I_vs_pol,
        input  O_de, O_hs, O_vs, O_sof, O_data_r, O_data_g, O_data_b, O_frame_cnt
    );
endinterface

// File: rtl/video_pattern_gen_vtg_timing.sv
// Video timing core: frame-shadowed timing config, H/V and frame counters, and the
// first pipeline stage (sync levels, DE, SOF and active-area x/y).
module vtg_timing #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] h_total, h_sync, h_bporch, h_res,
    input  logic [CNT_W-1:0] v_total, v_sync, v_bporch, v_res,
    input  logic             hs_pol, vs_pol,
    output logic             load,
    output logic             de, hs, vs, sof,
    output logic [CNT_W-1:0] x, y, hres, vres,
    output logic [15:0]      frame_cnt
);
    logic [CNT_W-1:0] h_total_s, h_sync_s, h_bporch_s, h_res_s;
    logic [CNT_W-1:0] v_total_s, v_sync_s, v_bporch_s, v_res_s;
    logic             hs_pol_s, vs_pol_s;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [15:0]      fcnt;
    logic             h_end, v_end, frame_end, h_act, v_act;
    logic [CNT_W:0]   h_start, h_stop, v_start, v_stop;

    assign h_end     = (h_cnt == h_total_s - CNT_W'(1));
    assign v_end     = (v_cnt == v_total_s - CNT_W'(1));
    assign frame_end = h_end && v_end;
    assign load      = !rst_n || frame_end;

    // Window bounds are one bit wider so large porch+res sums cannot wrap into range.
    assign h_start = {1'b0, h_sync_s} + {1'b0, h_bporch_s};
    assign h_stop  = h_start + {1'b0, h_res_s};
    assign v_start = {1'b0, v_sync_s} + {1'b0, v_bporch_s};
    assign v_stop  = v_start + {1'b0, v_res_s};
    assign h_act   = ({1'b0, h_cnt} >= h_start) && ({1'b0, h_cnt} < h_stop);
    assign v_act   = ({1'b0, v_cnt} >= v_start) && ({1'b0, v_cnt} < v_stop);

    always_ff @(posedge clk) begin
        if (load) begin
            h_total_s  <= h_total;
            h_sync_s   <= h_sync;
            h_bporch_s <= h_bporch;
            h_res_s    <= h_res;
            v_total_s  <= v_total;
            v_sync_s   <= v_sync;
            v_bporch_s <= v_bporch;
            v_res_s    <= v_res;
            hs_pol_s   <= hs_pol;
            vs_pol_s   <= vs_pol;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
            fcnt  <= '0;
        end else if (h_end) begin
            h_cnt <= '0;
            if (v_end) begin
                v_cnt <= '0;
                fcnt  <= fcnt + 16'd1;
            end else begin
                v_cnt <= v_cnt + CNT_W'(1);
            end
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de        <= 1'b0;
            hs        <= ~hs_pol;
            vs        <= ~vs_pol;
            sof       <= 1'b0;
            x         <= '0;
            y         <= '0;
            hres      <= '0;
            vres      <= '0;
            frame_cnt <= '0;
        end else begin
            de        <= h_act && v_act;
            hs        <= ~((h_cnt < h_sync_s) ^ hs_pol_s);
            vs        <= ~((v_cnt < v_sync_s) ^ vs_pol_s);
            sof       <= h_act && v_act && ({1'b0, h_cnt} == h_start) && ({1'b0, v_cnt} == v_start);
            x         <= h_cnt - h_start[CNT_W-1:0];
            y         <= v_cnt - v_start[CNT_W-1:0];
            hres      <= h_res_s;
            vres      <= v_res_s;
            frame_cnt <= fcnt;
        end
    end
endmodule

// File: rtl/video_pattern_gen.sv
// Video timing + test-pattern generator with a fixed 3-stage output pipeline.
// Define PATGEN_SCROLL_EN to scroll grid, horizontal ramp and checker by one pixel per frame.
module video_pattern_gen
    import patgen_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 12,
    parameter int BARS_LOG2 = 3,
    parameter int GRID_LOG2 = 5
) (
    input logic                 I_pxl_clk,
    input logic                 I_rst_n,
    video_pattern_gen_if.master vif
);
    localparam int NB = 1 << BARS_LOG2;
    localparam int XW = CNT_W + 3;

    logic              load, de1, hs1, vs1, sof1;
    logic [CNT_W-1:0]  x1, y1, hres1, vres1, xs, bar_w;
    logic [15:0]       fcnt1;
    logic [2:0]        mode_sh, mode1, bar_idx, colour;
    logic [DATA_W-1:0] single_r_sh, single_g_sh, single_b_sh;
    logic [DATA_W-1:0] single_r1, single_g1, single_b1;
    logic [DATA_W-1:0] pix_r, pix_g, pix_b;
    logic              de2, hs2, vs2, sof2;
    logic [15:0]       fcnt2;
    logic [DATA_W-1:0] r2, g2, b2;

    vtg_timing #(.CNT_W(CNT_W)) u_timing (
        .clk(I_pxl_clk), .rst_n(I_rst_n),
        .h_total(vif.I_h_total), .h_sync(vif.I_h_sync), .h_bporch(vif.I_h_bporch), .h_res(vif.I_h_res),
        .v_total(vif.I_v_total), .v_sync(vif.I_v_sync), .v_bporch(vif.I_v_bporch), .v_res(vif.I_v_res),
        .hs_pol(vif.I_hs_pol), .vs_pol(vif.I_vs_pol),
        .load(load), .de(de1), .hs(hs1), .vs(vs1), .sof(sof1),
        .x(x1), .y(y1), .hres(hres1), .vres(vres1), .frame_cnt(fcnt1)
    );

    // Pattern config shares the frame-boundary load with the timing shadows.
    always_ff @(posedge I_pxl_clk) begin
        if (load) begin
            mode_sh     <= vif.I_mode;
            single_r_sh <= vif.I_single_r;
            single_g_sh <= vif.I_single_g;
            single_b_sh <= vif.I_single_b;
        end
        mode1     <= mode_sh;
        single_r1 <= single_r_sh;
        single_g1 <= single_g_sh;
        single_b1 <= single_b_sh;
    end

`ifdef PATGEN_SCROLL_EN
    assign xs = x1 + CNT_W'(fcnt1);
`else
    assign xs = x1;
`endif

    assign bar_w = hres1 >> BARS_LOG2;

    // Bar index counts the bar boundaries already passed, which saturates naturally.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < NB; k++) begin
            if ({3'b000, x1} >= XW'(k) * {3'b000, bar_w})
                bar_idx = bar_idx + 3'd1;
        end
    end

    always_comb begin
        colour = COL_BLACK;
        case (mode1)
            PAT_BAR:   colour = bar_colour(3'(bar_idx << (3 - BARS_LOG2)));
            PAT_GRID:  colour = (xs[GRID_LOG2-1:0] == '0 || y1[GRID_LOG2-1:0] == '0 ||
                                 x1 == hres1 - CNT_W'(1) || y1 == vres1 - CNT_W'(1)) ? COL_RED : COL_BLACK;
            PAT_HRAMP, PAT_SINGLE, PAT_VRAMP: colour = COL_BLACK;
            PAT_CHECK: colour = (xs[GRID_LOG2] ^ y1[GRID_LOG2]) ? COL_WHITE : COL_BLACK;
            default:   colour = COL_BLUE;
        endcase
        pix_r = {DATA_W{colour[2]}};
        pix_g = {DATA_W{colour[1]}};
        pix_b = {DATA_W{colour[0]}};
        if (mode1 == PAT_HRAMP) begin
            pix_r = DATA_W'(xs);
            pix_g = DATA_W'(xs);
            pix_b = DATA_W'(xs);
        end else if (mode1 == PAT_VRAMP) begin
            pix_r = DATA_W'(y1);
            pix_g = DATA_W'(y1);
            pix_b = DATA_W'(y1);
        end else if (mode1 == PAT_SINGLE) begin
            pix_r = single_r1;
            pix_g = single_g1;
            pix_b = single_b1;
        end
        if (!de1) begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
        end
    end

    always_ff @(posedge I_pxl_clk) begin
        if (!I_rst_n) begin
            de2   <= 1'b0;
            hs2   <= ~vif.I_hs_pol;
            vs2   <= ~vif.I_vs_pol;
            sof2  <= 1'b0;
            fcnt2 <= '0;
            r2    <= '0;
            g2    <= '0;
            b2    <= '0;
            vif.O_de        <= 1'b0;
            vif.O_hs        <= ~vif.I_hs_pol;
            vif.O_vs        <= ~vif.I_vs_pol;
            vif.O_sof       <= 1'b0;
            vif.O_frame_cnt <= '0;
            vif.O_data_r    <= '0;
            vif.O_data_g    <= '0;
            vif.O_data_b    <= '0;
        end else begin
            de2   <= de1;
            hs2   <= hs1;
            vs2   <= vs1;
            sof2  <= sof1;
            fcnt2 <= fcnt1;
            r2    <= pix_r;
            g2    <= pix_g;
            b2    <= pix_b;
            vif.O_de        <= de2;
            vif.O_hs        <= hs2;
            vif.O_vs        <= vs2;
            vif.O_sof       <= sof2;
            vif.O_frame_cnt <= fcnt2;
            vif.O_data_r    <= r2;
            vif.O_data_g    <= g2;
            vif.O_data_b    <= b2;
        end
    end
endmodule
